sm_key_debouncer: RTL

Input-conditioning stage between the board push-buttons and the core/display wrapper. Synchronises and debounces the raw active-low button bus, then produces clean levels plus single-cycle press/release strobes; the board top uses these for CPU reset, clock enable and register-select instead of raw switch pins. Optional auto-repeat strobes support stepping the CPU clock by holding a key.

---
 rtl/sm_key_pkg.sv | 25 ++
 rtl/sm_key_debouncer_if.sv | 20 ++
 rtl/sm_key_debounce_1.sv | 154 +++++++++++++++
 rtl/sm_key_debouncer.sv | 44 ++++
 4 files changed

// File: rtl/sm_key_pkg.sv
// Shared constants and types for the push-button debouncer.
package sm_key_pkg;

   localparam int unsigned CLK_FREQ_HZ         = 50_000_000;
   localparam int unsigned DEF_KEYS            = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000;
   localparam int unsigned DEF_REPEAT_DELAY    = CLK_FREQ_HZ / 2;
   localparam int unsigned DEF_REPEAT_PERIOD   = CLK_FREQ_HZ / 10;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_FIRST  = 2'd1,
      RPT_PERIOD = 2'd2
   } rpt_state_e;

   // Raw pin level of a released button.
   function automatic logic released_level(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sm_key_debouncer_if.sv
// Button bus between the board pins and the debouncer: raw pins in, conditioned levels/strobes out.
interface sm_key_debouncer_if #(
   parameter int unsigned KEYS = 4
);
   logic [KEYS-1:0] keyIn;
   logic [KEYS-1:0] keyState;
   logic [KEYS-1:0] keyPress;
   logic [KEYS-1:0] keyRelease;
   logic [KEYS-1:0] keyRepeat;

   modport master (
      output keyIn,
      input  keyState, keyPress, keyRelease, keyRepeat
   );

   modport slave (
      input  keyIn,
      output keyState, keyPress, keyRelease, keyRepeat
   );
endinterface

// File: rtl/sm_key_debounce_1.sv
// One key: 2-flop synchroniser, debounce counter, press/release edge strobes.
// Auto-repeat strobes built only when SM_KEY_AUTOREPEAT_EN is defined.
module sm_key_debounce_1
   import sm_key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clkIn,
   input  logic rst_n,
   input  logic i_key,
   output logic o_state,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam bit          INV     = (ACTIVE_LOW != 0);
   localparam logic        REL_LVL = released_level(INV);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_state;
   logic             r_state_d;
   logic             r_press;
   logic             r_release;

   logic w_sample;
   logic w_differ;
   logic w_accept;
   logic w_rise;

   // Synchroniser resets to the released pin level so reset release never looks like a press.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= REL_LVL;
         r_sync2 <= REL_LVL;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sample = INV ? ~r_sync2 : r_sync2;
   assign w_differ = (w_sample != r_state);
   assign w_accept = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign w_rise   = r_state & ~r_state_d;

   // Any agreement with the accepted level restarts the persistence count.
   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_state <= 1'b0;
      end else begin
         if (!w_differ || w_accept) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_state <= w_sample;
         end
      end
   end

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         r_state_d <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_state_d <= r_state;
         r_press   <= w_rise;
         r_release <= ~r_state & r_state_d;
      end
   end

   assign o_state   = r_state;
   assign o_press   = r_press;
   assign o_release = r_release;

`ifdef SM_KEY_AUTOREPEAT_EN
   localparam int unsigned RPT_MAX = max_u(max_u(REPEAT_DELAY, REPEAT_PERIOD), 2);
   localparam int unsigned RPT_W   = $clog2(RPT_MAX);

   rpt_state_e       r_rpt_st;
   rpt_state_e       w_rpt_st_n;
   logic [RPT_W-1:0] r_rcnt;
   logic [RPT_W-1:0] w_rcnt_n;
   logic             r_repeat;
   logic             w_repeat_n;

   always_ff @(posedge clkIn or negedge rst_n) begin
      if (!rst_n) begin
         r_rpt_st <= RPT_IDLE;
         r_rcnt   <= '0;
         r_repeat <= 1'b0;
      end else begin
         r_rpt_st <= w_rpt_st_n;
         r_rcnt   <= w_rcnt_n;
         r_repeat <= w_repeat_n;
      end
   end

   // Counter restarts in the press-strobe cycle; first strobe uses the delay, later ones the period.
   always_comb begin
      w_rpt_st_n = r_rpt_st;
      w_rcnt_n   = r_rcnt;
      w_repeat_n = 1'b0;
      if (!r_state) begin
         w_rpt_st_n = RPT_IDLE;
         w_rcnt_n   = '0;
      end else if (w_rise) begin
         w_rpt_st_n = RPT_FIRST;
         w_rcnt_n   = '0;
      end else begin
         case (r_rpt_st)
            RPT_FIRST: begin
               if (r_rcnt == RPT_W'(REPEAT_DELAY - 1)) begin
                  w_repeat_n = 1'b1;
                  w_rcnt_n   = '0;
                  w_rpt_st_n = RPT_PERIOD;
               end else begin
                  w_rcnt_n = r_rcnt + RPT_W'(1);
               end
            end
            RPT_PERIOD: begin
               if (r_rcnt == RPT_W'(REPEAT_PERIOD - 1)) begin
                  w_repeat_n = 1'b1;
                  w_rcnt_n   = '0;
               end else begin
                  w_rcnt_n = r_rcnt + RPT_W'(1);
               end
            end
            default: begin
               w_rpt_st_n = RPT_IDLE;
               w_rcnt_n   = '0;
            end
         endcase
      end
   end

   assign o_repeat = r_repeat;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
   assign o_repeat     = 1'b0;
`endif

endmodule

// File: rtl/sm_key_debouncer.sv
// Push-button conditioning: KEYS independent debounce lanes on the button bus.
// Define SM_KEY_AUTOREPEAT_EN to build the auto-repeat strobes; otherwise keyRepeat is 0.
module sm_key_debouncer
   import sm_key_pkg::*;
#(
   parameter int unsigned KEYS            = DEF_KEYS,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input logic               clkIn,
   input logic               rst_n,
   sm_key_debouncer_if.slave bus
);

   logic [KEYS-1:0] w_state;
   logic [KEYS-1:0] w_press;
   logic [KEYS-1:0] w_release;
   logic [KEYS-1:0] w_repeat;

   for (genvar g = 0; g < KEYS; g++) begin : g_key
      sm_key_debounce_1 #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_key (
         .clkIn     (clkIn),
         .rst_n     (rst_n),
         .i_key     (bus.keyIn[g]),
         .o_state   (w_state[g]),
         .o_press   (w_press[g]),
         .o_release (w_release[g]),
         .o_repeat  (w_repeat[g])
      );
   end

   assign bus.keyState   = w_state;
   assign bus.keyPress   = w_press;
   assign bus.keyRelease = w_release;
   assign bus.keyRepeat  = w_repeat;

endmodule
